// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read mode.
// The count, threshold flags and error pulses are registered from the next-state occupancy.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDR_WIDTH          = 4,
  parameter bit FWFT                = 1'b0,
  parameter int ALMOST_FULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C     = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C     = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] ZERO_C   = '0;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, full_d;
  logic                  af_q, af_d;
  logic                  empty_q, empty_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_rd;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic [DATA_WIDTH-1:0] head_word;

  assign head_word = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

  always_comb begin
    wr_acc     = wr_en && !full_q;
    rd_acc     = rd_en && !empty_q;
    mem_rd     = 1'b0;
    mem_cnt    = count_q - (ADDR_WIDTH+1)'(rd_valid_q);
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    if (FWFT) begin
      // The prefetch register refills whenever it is empty or being popped; words
      // written on this same edge are not yet readable, so they land one edge later.
      if ((!rd_valid_q || rd_acc) && (mem_cnt != ZERO_C)) begin
        mem_rd     = 1'b1;
        rd_data_d  = head_word;
        rd_valid_d = 1'b1;
      end else if (rd_acc) begin
        rd_valid_d = 1'b0;
      end
    end else begin
      rd_valid_d = rd_acc;
      if (rd_acc) begin
        mem_rd    = 1'b1;
        rd_data_d = head_word;
      end
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(mem_rd);

    full_d  = (count_d == DEPTH_C);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    empty_d = FWFT ? !rd_valid_d : (count_d == ZERO_C);
    ovf_d   = wr_en && !wr_acc;
    unf_d   = rd_en && !rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      empty_q    <= 1'b1;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      af_q       <= af_d;
      empty_q    <= empty_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  assign full         = full_q;
  assign almost_full  = af_q;
  assign overflow     = ovf_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign underflow    = unf_q;
  assign count        = count_q;

endmodule
